// File: rtl/julia_pkg.sv
// Shared SDRAM command encodings, frame geometry and read-pointer helper.
// Combinational helpers only; no state lives here.
// Imported by the arbiter and any block that talks to the SDRAM controller.
package julia_pkg;

    localparam int ADDR_W            = 22;
    localparam int DATA_W            = 32;
    localparam int READ_BURST_LENGTH = 8;
    localparam int FRAME_WORDS       = 96000;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } cmd_t;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } arb_state_t;

    // Display scan-out wraps at the end of the frame rather than at the address width.
    function automatic logic [ADDR_W-1:0] next_rd_ptr(input logic [ADDR_W-1:0] ptr,
                                                      input int frame_words);
        return (ptr == ADDR_W'(frame_words - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Arbitrates display-refresh reads against renderer writes onto one SDRAM controller port.
// Latency: grant registered one cycle after an IDLE decision; rd_data/rd_valid pass straight through.
// Backpressure: reads gated by FIFO fill hysteresis; writes held by level wr_req until wr_ack.
module sdram_arbiter
    import julia_pkg::*;
#(
    parameter int READ_BURST_LENGTH = julia_pkg::READ_BURST_LENGTH,
    parameter int FRAME_WORDS       = julia_pkg::FRAME_WORDS,
    parameter int MAX_READ_RUN      = 4,
    parameter int HOLDOFF           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_enable,
    input  logic              fifo_low,
    input  logic              fifo_high,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              first_data_ready,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [1:0]        command,
    output logic [ADDR_W-1:0] data_address,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    input  logic              data_read_valid,
    input  logic              data_write_done
);

    localparam int HOLD_W  = $clog2(HOLDOFF + 1);
    localparam int BURST_W = $clog2(READ_BURST_LENGTH + 1);
    localparam int RUN_W   = $clog2(MAX_READ_RUN + 1);

    arb_state_t        state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BURST_W-1:0] burst_left;
    logic [RUN_W-1:0]   run_count;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0]  rd_ptr_nxt;
    logic               fill;
    logic               fill_now;
    logic               read_ok;
    logic               write_ok;
    logic               write_first;

    assign rd_ptr_nxt = next_rd_ptr(rd_ptr, FRAME_WORDS);

    // fifo_high always wins so a full FIFO stops refills even on the cycle fifo_low is seen.
    assign fill_now    = (fill || (state == ST_IDLE && fifo_low)) && !fifo_high;
    assign read_ok     = rd_enable && fill_now;
    // The ack cycle masks wr_req so a renderer that drops it one cycle late is not re-granted.
    assign write_ok    = wr_req && !wr_ack;
    assign write_first = write_ok && (run_count == RUN_W'(MAX_READ_RUN));

    assign rd_valid = data_read_valid && (state == ST_READ);
    assign rd_data  = data_read;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_HOLD;
            hold_cnt         <= '0;
            burst_left       <= '0;
            run_count        <= '0;
            rd_ptr           <= '0;
            fill             <= 1'b0;
            wr_ack           <= 1'b0;
            first_data_ready <= 1'b0;
            command          <= CMD_IDLE;
            data_address     <= '0;
            data_write       <= '0;
        end else begin
            fill   <= fill_now;
            wr_ack <= 1'b0;
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLDOFF - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (read_ok && !write_first) begin
                        state        <= ST_READ;
                        command      <= CMD_READ;
                        data_address <= rd_ptr;
                        burst_left   <= BURST_W'(READ_BURST_LENGTH);
                    end else if (write_ok) begin
                        state        <= ST_WRITE;
                        command      <= CMD_WRITE;
                        data_address <= wr_addr;
                        data_write   <= wr_data;
                    end
                end
                ST_READ: begin
                    // Bursts always run to full length; fill only gates the next grant.
                    if (data_read_valid) begin
                        rd_ptr       <= rd_ptr_nxt;
                        data_address <= rd_ptr_nxt;
                        burst_left   <= burst_left - 1'b1;
                        if (burst_left == BURST_W'(1)) begin
                            state            <= ST_IDLE;
                            command          <= CMD_IDLE;
                            first_data_ready <= 1'b1;
                            if (run_count != RUN_W'(MAX_READ_RUN)) begin
                                run_count <= run_count + 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (data_write_done) begin
                        state     <= ST_IDLE;
                        command   <= CMD_IDLE;
                        wr_ack    <= 1'b1;
                        run_count <= '0;
                    end
                end
                default: state <= ST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: random-latency SDRAM controller and renderer models, frame-pointer scoreboard.
module tb_sdram_arbiter;

    localparam int RBL    = 8;
    localparam int FW     = 20;
    localparam int MAXRUN = 4;
    localparam int HOLD   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_enable, fifo_low, fifo_high;
    logic [31:0] rd_data;
    logic        rd_valid, first_data_ready;
    logic        wr_req;
    logic [21:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [1:0]  command;
    logic [21:0] data_address;
    logic [31:0] data_write, data_read;
    logic        data_read_valid, data_write_done;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .READ_BURST_LENGTH(RBL),
        .FRAME_WORDS      (FW),
        .MAX_READ_RUN     (MAXRUN),
        .HOLDOFF          (HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rd_enable       (rd_enable),
        .fifo_low        (fifo_low),
        .fifo_high       (fifo_high),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .first_data_ready(first_data_ready),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .command         (command),
        .data_address    (data_address),
        .data_write      (data_write),
        .data_read       (data_read),
        .data_read_valid (data_read_valid),
        .data_write_done (data_write_done)
    );

    int vectors = 0;
    int miscompares = 0;

    bit          ctl_en = 1'b1;
    bit          ctl_stall_wr = 1'b0;
    bit          auto_drop = 1'b1;
    int          sent = 0;
    int          wr_wait = 0;
    int          bursts_done = 0;
    int          acks = 0;
    int          b2b = 0;
    int          exp_ptr = 0;
    logic [1:0]  prev_cmd = 2'd0;
    logic [1:0]  grant_log[$];
    logic [31:0] words[$];
    logic [21:0] cap_addr;
    logic [31:0] cap_data;

    function automatic logic [31:0] word_at(input int a);
        return {10'h2A5, 22'(a)};
    endfunction

    // One clock: capture FIFO writes mid-cycle, then observe registered outputs and act as controller/renderer.
    task automatic tick();
        @(negedge clk);
        if (rd_valid) words.push_back(rd_data);
        @(posedge clk);
        #1;
        if (command != 2'd0 && command != prev_cmd) begin
            grant_log.push_back(command);
            if (prev_cmd != 2'd0) b2b++;
            if (command == 2'd1) begin
                cap_addr = data_address;
                cap_data = data_write;
            end
        end
        if (prev_cmd == 2'd2 && command != 2'd2) bursts_done++;
        if (wr_ack) begin
            acks++;
            if (auto_drop) wr_req = 1'b0;
        end
        prev_cmd = command;
        if (ctl_en) begin
            if (command == 2'd2 && sent < RBL && $urandom_range(3) != 0) begin
                data_read_valid = 1'b1;
                data_read       = word_at(int'(data_address));
                sent++;
            end else begin
                data_read_valid = 1'b0;
                data_read       = $urandom;
            end
            if (command != 2'd2) sent = 0;
            if (command == 2'd1 && !ctl_stall_wr) begin
                if (wr_wait >= 2) begin
                    data_write_done = 1'b1;
                end else begin
                    data_write_done = 1'b0;
                    wr_wait++;
                end
            end else begin
                data_write_done = 1'b0;
                wr_wait = 0;
            end
        end
    endtask

    task automatic wait_bursts(input int target, output bit to);
        int i = 0;
        while (bursts_done < target && i < 400) begin
            tick();
            i++;
        end
        to = (bursts_done < target);
    endtask

    task automatic wait_cmd(input logic [1:0] v, output bit to);
        int i = 0;
        while (command !== v && i < 400) begin
            tick();
            i++;
        end
        to = (command !== v);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rd_enable = 1'b0; fifo_low = 1'b0; fifo_high = 1'b0; wr_req = 1'b0;
        data_read_valid = 1'b0; data_write_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        prev_cmd = 2'd0; exp_ptr = 0; sent = 0; wr_wait = 0; bursts_done = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rd_enable = 1'b0; fifo_low = 1'b0; fifo_high = 1'b0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; data_read = 32'hDEADBEEF;
        data_read_valid = 1'b1; data_write_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (command !== 2'd0) begin miscompares++; $display("FAIL reset_command: got %0d expected 0", command); end
        vectors++; if (data_address !== 22'd0) begin miscompares++; $display("FAIL reset_address: got %h expected 0", data_address); end
        vectors++; if (data_write !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", data_write); end
        vectors++; if (wr_ack !== 1'b0) begin miscompares++; $display("FAIL reset_wr_ack: got %b expected 0", wr_ack); end
        vectors++; if (first_data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_fdr: got %b expected 0", first_data_ready); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        data_read_valid = 1'b0;
    endtask

    task automatic test_first_read();
        bit to;
        fifo_low = 1'b1; rd_enable = 1'b1;
        reset = 1'b0;
        prev_cmd = 2'd0; exp_ptr = 0;
        repeat (HOLD) tick();
        vectors++; if (command !== 2'd0 || grant_log.size() != 0) begin miscompares++; $display("FAIL holdoff_grant: cmd %0d grants %0d expected 0/0", command, grant_log.size()); end
        tick();
        vectors++; if (command !== 2'd2) begin miscompares++; $display("FAIL first_grant_cycle17: got cmd %0d expected 2", command); end
        vectors++; if (data_address !== 22'd0) begin miscompares++; $display("FAIL first_grant_addr: got %0d expected 0", data_address); end
        rd_enable = 1'b0;
        wait_bursts(1, to);
        vectors++; if (to) begin miscompares++; $display("FAIL first_burst_timeout: got bursts %0d expected 1", bursts_done); end
        vectors++; if (first_data_ready !== 1'b1) begin miscompares++; $display("FAIL first_data_ready: got %b expected 1", first_data_ready); end
        vectors++; if (words.size() != RBL) begin miscompares++; $display("FAIL first_word_count: got %0d expected %0d", words.size(), RBL); end
        while (words.size() > 0) begin
            logic [31:0] w = words.pop_front();
            vectors++; if (w !== word_at(exp_ptr)) begin miscompares++; $display("FAIL first_word: got %h expected %h", w, word_at(exp_ptr)); end
            exp_ptr = (exp_ptr + 1) % FW;
        end
        repeat (5) tick();
        vectors++; if (command !== 2'd0) begin miscompares++; $display("FAIL rd_enable_block: got cmd %0d expected 0", command); end
        rd_enable = 1'b1;
        wait_cmd(2'd2, to);
        vectors++; if (to || data_address !== 22'(exp_ptr)) begin miscompares++; $display("FAIL rd_ptr_retained: got %0d expected %0d", data_address, exp_ptr); end
    endtask

    task automatic test_wrap();
        bit to;
        wait_bursts(3, to);
        rd_enable = 1'b0;
        vectors++; if (to) begin miscompares++; $display("FAIL wrap_timeout: got bursts %0d expected 3", bursts_done); end
        vectors++; if (words.size() != 2 * RBL) begin miscompares++; $display("FAIL wrap_word_count: got %0d expected %0d", words.size(), 2 * RBL); end
        while (words.size() > 0) begin
            logic [31:0] w = words.pop_front();
            vectors++; if (w !== word_at(exp_ptr)) begin miscompares++; $display("FAIL wrap_word: got %h expected %h", w, word_at(exp_ptr)); end
            exp_ptr = (exp_ptr + 1) % FW;
        end
        rd_enable = 1'b1;
        wait_cmd(2'd2, to);
        vectors++; if (to || data_address !== 22'(exp_ptr)) begin miscompares++; $display("FAIL wrap_ptr: got %0d expected %0d", data_address, exp_ptr); end
        rd_enable = 1'b0;
        wait_bursts(4, to);
        vectors++; if (to) begin miscompares++; $display("FAIL wrap_tail_timeout: got bursts %0d expected 4", bursts_done); end
        while (words.size() > 0) begin
            logic [31:0] w = words.pop_front();
            vectors++; if (w !== word_at(exp_ptr)) begin miscompares++; $display("FAIL wrap_tail_word: got %h expected %h", w, word_at(exp_ptr)); end
            exp_ptr = (exp_ptr + 1) % FW;
        end
    endtask

    task automatic test_write_fairness();
        bit to;
        int i = 0;
        logic [21:0] a;
        logic [31:0] d;
        logic [1:0]  exp_log[$];
        apply_reset();
        grant_log.delete(); words.delete(); acks = 0; b2b = 0;
        a = 22'($urandom); d = $urandom;
        wr_addr = a; wr_data = d; wr_req = 1'b1; auto_drop = 1'b1;
        fifo_low = 1'b1; rd_enable = 1'b1;
        while (acks < 1 && i < 2000) begin tick(); i++; end
        vectors++; if (acks < 1) begin miscompares++; $display("FAIL fair_ack_timeout: got acks %0d expected 1", acks); end
        wait_cmd(2'd2, to);
        rd_enable = 1'b0;
        wait_bursts(MAXRUN + 1, to);
        vectors++; if (to) begin miscompares++; $display("FAIL fair_resume_timeout: got bursts %0d expected %0d", bursts_done, MAXRUN + 1); end
        for (int k = 0; k < MAXRUN; k++) exp_log.push_back(2'd2);
        exp_log.push_back(2'd1);
        exp_log.push_back(2'd2);
        vectors++; if (grant_log.size() != exp_log.size()) begin miscompares++; $display("FAIL fair_grant_count: got %0d expected %0d", grant_log.size(), exp_log.size()); end
        for (int k = 0; k < exp_log.size() && k < grant_log.size(); k++) begin
            vectors++; if (grant_log[k] !== exp_log[k]) begin miscompares++; $display("FAIL fair_grant_%0d: got cmd %0d expected %0d", k, grant_log[k], exp_log[k]); end
        end
        vectors++; if (acks != 1) begin miscompares++; $display("FAIL fair_ack_pulses: got %0d expected 1", acks); end
        vectors++; if (cap_addr !== a || cap_data !== d) begin miscompares++; $display("FAIL fair_write_latch: got %h/%h expected %h/%h", cap_addr, cap_data, a, d); end
        vectors++; if (b2b != 0) begin miscompares++; $display("FAIL back_to_back: got %0d expected 0", b2b); end
        while (words.size() > 0) begin
            logic [31:0] w = words.pop_front();
            vectors++; if (w !== word_at(exp_ptr)) begin miscompares++; $display("FAIL fair_word: got %h expected %h", w, word_at(exp_ptr)); end
            exp_ptr = (exp_ptr + 1) % FW;
        end
    endtask

    task automatic test_fifo_high();
        bit to;
        int i = 0;
        int b0 = bursts_done;
        int g0;
        int busy = 0;
        fifo_low = 1'b0; rd_enable = 1'b1;
        wait_cmd(2'd2, to);
        vectors++; if (to) begin miscompares++; $display("FAIL high_grant_timeout: got cmd %0d expected 2", command); end
        while (words.size() < 3 && i < 400) begin tick(); i++; end
        fifo_high = 1'b1;
        wait_bursts(b0 + 1, to);
        fifo_high = 1'b0;
        vectors++; if (to || command !== 2'd0) begin miscompares++; $display("FAIL high_burst_end: got cmd %0d expected 0", command); end
        vectors++; if (words.size() != RBL) begin miscompares++; $display("FAIL high_full_burst: got %0d words expected %0d", words.size(), RBL); end
        while (words.size() > 0) begin
            logic [31:0] w = words.pop_front();
            vectors++; if (w !== word_at(exp_ptr)) begin miscompares++; $display("FAIL high_word: got %h expected %h", w, word_at(exp_ptr)); end
            exp_ptr = (exp_ptr + 1) % FW;
        end
        g0 = grant_log.size();
        repeat (20) begin tick(); if (command != 2'd0) busy++; end
        vectors++; if (busy != 0 || grant_log.size() != g0) begin miscompares++; $display("FAIL high_fill_cleared: got %0d busy cycles expected 0", busy); end
        rd_enable = 1'b0;
    endtask

    task automatic test_reset_write();
        bit to;
        int i = 0;
        int busy = 0;
        acks = 0; ctl_stall_wr = 1'b1; auto_drop = 1'b1;
        wr_addr = 22'h00100; wr_data = $urandom; wr_req = 1'b1;
        wait_cmd(2'd1, to);
        vectors++; if (to || data_address !== 22'h00100) begin miscompares++; $display("FAIL rstwr_grant: got addr %h expected 000100", data_address); end
        repeat (3) tick();
        reset = 1'b1;
        #1;
        vectors++; if (command !== 2'd0) begin miscompares++; $display("FAIL rstwr_async_cmd: got %0d expected 0", command); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        prev_cmd = 2'd0; exp_ptr = 0; sent = 0; wr_wait = 0;
        data_write_done = 1'b0; ctl_stall_wr = 1'b0;
        repeat (HOLD) begin tick(); if (command != 2'd0) busy++; end
        vectors++; if (busy != 0) begin miscompares++; $display("FAIL rstwr_holdoff: got %0d busy cycles expected 0", busy); end
        vectors++; if (acks != 0) begin miscompares++; $display("FAIL rstwr_no_ack: got %0d acks expected 0", acks); end
        tick();
        vectors++; if (command !== 2'd1) begin miscompares++; $display("FAIL rstwr_regrant: got cmd %0d expected 1", command); end
        while (acks < 1 && i < 400) begin tick(); i++; end
        vectors++; if (acks != 1 || cap_addr !== 22'h00100) begin miscompares++; $display("FAIL rstwr_retry: got acks %0d addr %h expected 1/000100", acks, cap_addr); end
    endtask

    task automatic test_stray_valid();
        bit to;
        int b0;
        ctl_en = 1'b0;
        words.delete();
        repeat (6) begin
            data_read_valid = 1'b1;
            data_read = $urandom;
            #2;
            vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL stray_rd_valid: got %b expected 0", rd_valid); end
            tick();
        end
        data_read_valid = 1'b0;
        ctl_en = 1'b1;
        vectors++; if (words.size() != 0) begin miscompares++; $display("FAIL stray_captured: got %0d words expected 0", words.size()); end
        b0 = bursts_done;
        fifo_low = 1'b1; rd_enable = 1'b1;
        wait_cmd(2'd2, to);
        vectors++; if (to || data_address !== 22'(exp_ptr)) begin miscompares++; $display("FAIL stray_ptr: got %0d expected %0d", data_address, exp_ptr); end
        rd_enable = 1'b0;
        wait_bursts(b0 + 1, to);
        vectors++; if (to || words.size() != RBL) begin miscompares++; $display("FAIL stray_burst: got %0d words expected %0d", words.size(), RBL); end
        while (words.size() > 0) begin
            logic [31:0] w = words.pop_front();
            vectors++; if (w !== word_at(exp_ptr)) begin miscompares++; $display("FAIL stray_word: got %h expected %h", w, word_at(exp_ptr)); end
            exp_ptr = (exp_ptr + 1) % FW;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_read();
        test_wrap();
        test_write_fairness();
        test_fifo_high();
        test_reset_write();
        test_stray_valid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
